ship_fire_scheduler: RTL and testbench

Fire controller for the player ship's projectile pool. It turns the keyboard fire level into one-frame activation pulses and steers each pulse to a free projectile slot. It enforces a refire cooldown and tracks shots in flight. It sits between the keyboard decode and the array of ship-projectile instances, and consumes each slot's enable output as its busy status.

---
 rtl/ship_fire_scheduler_pkg.sv | 27 ++
 rtl/ship_fire_scheduler_slot_picker.sv | 25 ++
 rtl/ship_fire_scheduler.sv | 165 ++++++++++++++++
 tb/tb_ship_fire_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ship_fire_scheduler_pkg.sv
// Shared types and constants for the player ship fire path.
// Holds the fire FSM state type, the default slot count and cooldown,
// and a popcount helper used for the in-flight count.
package ship_fire_scheduler_pkg;

    localparam int NUM_SHIP_PROJ      = 2;
    localparam int SHIP_FIRE_COOLDOWN = 8;

    // Raw encodings kept as plain constants for older code that compares bits
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_COOL = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        COOL = ST_COOL
    } fire_state_t;

    function automatic logic [3:0] popCount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ship_fire_scheduler_slot_picker.sv
// ship_slot_picker: lowest-index priority encoder over the free-slot vector.
// Produces a one-hot grant and a flag saying any slot is free.
module ship_slot_picker #(
    parameter int NUM_SLOTS = 2
) (
    input  logic [NUM_SLOTS-1:0] free,
    output logic [NUM_SLOTS-1:0] grant,
    output logic                 any
);

    // Scan upward and keep only the first free slot
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (free[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/ship_fire_scheduler.sv
// ship_fire_scheduler: turns the fire key into one-frame activation pulses
// steered to a free ship-projectile slot, with refire cooldown and a short
// reservation (pending) on each issued slot until its enable comes up.
// Build option: SHIP_AUTOFIRE_EN -- a held key re-fires every time the
// cooldown expires instead of needing a release and re-press.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready; a fire request issues a shot or a dry-fire pulse
// COOL  | refire cooldown running; fire requests are dropped
module ship_fire_scheduler
    import ship_fire_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS    = NUM_SHIP_PROJ,
    parameter int COOLDOWN     = SHIP_FIRE_COOLDOWN,
    parameter int PEND_TIMEOUT = 3
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  logic                 FireBtn,
    input  logic                 ShipAlive,
    input  logic [NUM_SLOTS-1:0] SlotEn,
    output logic [NUM_SLOTS-1:0] SlotActvt,
    output logic                 DryFire,
    output logic                 CoolBusy,
    output logic [3:0]           InFlight,
    output logic [7:0]           ShotCount
);

    localparam int PW = (PEND_TIMEOUT < 2) ? 1 : $clog2(PEND_TIMEOUT + 1);
    localparam logic [7:0]    COOL_LOAD = (COOLDOWN == 0) ? 8'd0 : 8'(COOLDOWN - 1);
    localparam logic [PW-1:0] PEND_LOAD = PW'(PEND_TIMEOUT);

    fire_state_t          state;
    logic [7:0]           coolCnt;
    logic                 fireQ;
    logic                 fireReq;
    logic [NUM_SLOTS-1:0] pending;
    logic [PW-1:0]        pendCnt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy;
    logic [NUM_SLOTS-1:0] grant;
    logic                 anyFree;
    logic                 issue;
    logic                 dryReq;
    logic [7:0]           busyWide;

    // A slot waiting for its enable still counts as occupied
    assign busy = SlotEn | pending;

    ship_slot_picker #(.NUM_SLOTS(NUM_SLOTS)) picker (
        .free  (~busy),
        .grant (grant),
        .any   (anyFree)
    );

`ifdef SHIP_AUTOFIRE_EN
    logic autoArm;

    // Remember that cooldown ended with the key still down
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            autoArm <= 1'b0;
        end else begin
            autoArm <= (state == COOL) && (coolCnt == 8'd0) && FireBtn && ShipAlive;
        end
    end

    assign fireReq = (FireBtn & ~fireQ) | (autoArm & FireBtn);
`else
    assign fireReq = FireBtn & ~fireQ;
`endif

    assign issue  = (state == IDLE) && fireReq && ShipAlive && anyFree;
    assign dryReq = (state == IDLE) && fireReq && ShipAlive && !anyFree;

    // Key history for edge detect; held high while dead so respawn needs a fresh press
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fireQ <= 1'b1;
        end else begin
            fireQ <= ShipAlive ? FireBtn : 1'b1;
        end
    end

    // Fire state machine and cooldown down-counter
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            coolCnt <= 8'd0;
        end else if (!ShipAlive) begin
            state   <= IDLE;
            coolCnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && (COOLDOWN != 0)) begin
                        state   <= COOL;
                        coolCnt <= COOL_LOAD;
                    end
                end
                COOL: begin
                    if (coolCnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        coolCnt <= coolCnt - 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    coolCnt <= 8'd0;
                end
            endcase
        end
    end

    // Registered pulses, cooldown flag and saturating shot counter
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            SlotActvt <= '0;
            DryFire   <= 1'b0;
            CoolBusy  <= 1'b0;
            ShotCount <= 8'd0;
        end else begin
            SlotActvt <= issue ? grant : '0;
            DryFire   <= dryReq;
            CoolBusy  <= (state == COOL);
            if (issue && (ShotCount != 8'hFF)) begin
                ShotCount <= ShotCount + 8'd1;
            end
        end
    end

    // Per-slot reservation: set on issue, dropped on first enable or timeout
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pendCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (issue && grant[i]) begin
                    pending[i] <= 1'b1;
                    pendCnt[i] <= PEND_LOAD;
                end else if (pending[i]) begin
                    if (SlotEn[i] || (pendCnt[i] == '0) || (pendCnt[i] == PW'(1))) begin
                        pending[i] <= 1'b0;
                        pendCnt[i] <= '0;
                    end else begin
                        pendCnt[i] <= pendCnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    // Widen the occupied vector so one popcount covers any slot count
    always_comb begin
        busyWide = '0;
        busyWide[NUM_SLOTS-1:0] = busy;
    end

    assign InFlight = popCount8(busyWide);

endmodule

// File: tb/tb_ship_fire_scheduler.sv
// Directed bench for ship_fire_scheduler with default parameters
// (2 slots, cooldown 8, pending timeout 3). Frame F is the interval that
// starts at the F-th rising edge after reset release; outputs are read
// 1 time unit after that edge, inputs set there are sampled at its end.
module tb_ship_fire_scheduler;

    logic       frame_clk;
    logic       Reset_n;
    logic       FireBtn;
    logic       ShipAlive;
    logic [1:0] SlotEn;
    logic [1:0] SlotActvt;
    logic       DryFire;
    logic       CoolBusy;
    logic [3:0] InFlight;
    logic [7:0] ShotCount;

    int vectors     = 0;
    int miscompares = 0;
    int frame       = 0;
    int pulses      = 0;
    int badPulse    = 0;
    int expPulses;
    int expShots;

    ship_fire_scheduler dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .FireBtn   (FireBtn),
        .ShipAlive (ShipAlive),
        .SlotEn    (SlotEn),
        .SlotActvt (SlotActvt),
        .DryFire   (DryFire),
        .CoolBusy  (CoolBusy),
        .InFlight  (InFlight),
        .ShotCount (ShotCount)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s (frame %0d): observed %0h expected %0h", tag, frame, obs, exp);
        end
    endtask

    task automatic nextFrame();
        @(posedge frame_clk);
        #1;
        frame++;
    endtask

    task automatic gotoFrame(input int f);
        while (frame < f) nextFrame();
    endtask

    initial begin
`ifdef SHIP_AUTOFIRE_EN
        expPulses = 6;
`else
        expPulses = 1;
`endif
        expShots = 4 + expPulses;

        Reset_n   = 1'b0;
        FireBtn   = 1'b0;
        ShipAlive = 1'b1;
        SlotEn    = 2'b00;
        #2;
        chk("rst_actvt",  SlotActvt, 2'b00);
        chk("rst_dry",    DryFire,   1'b0);
        chk("rst_cool",   CoolBusy,  1'b0);
        chk("rst_flight", InFlight,  4'd0);
        chk("rst_shots",  ShotCount, 8'd0);
        #1 Reset_n = 1'b1;

        // First shot: press in frame 10, pulse to slot 0 in frame 11 only
        gotoFrame(10);
        FireBtn = 1'b1;
        nextFrame();
        chk("shot1_actvt",  SlotActvt, 2'b01);
        chk("shot1_flight", InFlight,  4'd1);
        chk("shot1_cool11", CoolBusy,  1'b0);
        nextFrame();
        chk("shot1_width",  SlotActvt, 2'b00);
        chk("shot1_cool12", CoolBusy,  1'b1);
        chk("shot1_count",  ShotCount, 8'd1);
        SlotEn  = 2'b01;
        FireBtn = 1'b0;

        // Press during cooldown is dropped without a dry-fire
        gotoFrame(15);
        FireBtn = 1'b1;
        nextFrame();
        chk("cool_drop_actvt", SlotActvt, 2'b00);
        chk("cool_drop_dry",   DryFire,   1'b0);
        FireBtn = 1'b0;
        gotoFrame(19);
        chk("cool_last", CoolBusy, 1'b1);
        nextFrame();
        chk("cool_end",  CoolBusy, 1'b0);

        // Slot 0 busy: second shot goes to slot 1
        gotoFrame(25);
        FireBtn = 1'b1;
        nextFrame();
        chk("shot2_actvt",  SlotActvt, 2'b10);
        chk("shot2_count",  ShotCount, 8'd2);
        chk("shot2_flight", InFlight,  4'd2);
        FireBtn = 1'b0;
        nextFrame();
        SlotEn = 2'b11;

        // Both slots busy: dry-fire for one frame, nothing issued
        gotoFrame(40);
        FireBtn = 1'b1;
        nextFrame();
        chk("dry_pulse", DryFire,   1'b1);
        chk("dry_actvt", SlotActvt, 2'b00);
        chk("dry_count", ShotCount, 8'd2);
        FireBtn = 1'b0;
        nextFrame();
        chk("dry_width", DryFire, 1'b0);

        // Shot whose enable never rises: reserved frames 46..48, free at 49
        gotoFrame(45);
        SlotEn  = 2'b00;
        FireBtn = 1'b1;
        nextFrame();
        chk("tmo_actvt",  SlotActvt, 2'b01);
        chk("tmo_count",  ShotCount, 8'd3);
        chk("tmo_fl46",   InFlight,  4'd1);
        FireBtn = 1'b0;
        gotoFrame(48);
        chk("tmo_fl48",   InFlight,  4'd1);
        nextFrame();
        chk("tmo_fl49",   InFlight,  4'd0);

        // Slot 0 enable falls in the same frame as the press: slot 0 is free
        gotoFrame(56);
        SlotEn = 2'b11;
        gotoFrame(58);
        SlotEn  = 2'b10;
        FireBtn = 1'b1;
        nextFrame();
        chk("fall_actvt",  SlotActvt, 2'b01);
        chk("fall_flight", InFlight,  4'd2);
        chk("fall_count",  ShotCount, 8'd4);
        FireBtn = 1'b0;

        // Key held frames 70..119
        gotoFrame(70);
        SlotEn  = 2'b00;
        FireBtn = 1'b1;
        while (frame < 125) begin
            nextFrame();
            if (frame == 120) FireBtn = 1'b0;
            if (SlotActvt != 2'b00) begin
                pulses++;
                if ((SlotActvt != 2'b01) || ((frame - 71) % 9 != 0)) badPulse++;
            end
        end
        chk("hold_pulses", pulses,    expPulses);
        chk("hold_shape",  badPulse,  0);
        chk("hold_count",  ShotCount, expShots);

        // Dead ship ignores the press; held key does not fire on respawn
        gotoFrame(130);
        FireBtn   = 1'b1;
        ShipAlive = 1'b0;
        nextFrame();
        chk("dead_actvt", SlotActvt, 2'b00);
        chk("dead_dry",   DryFire,   1'b0);
        ShipAlive = 1'b1;
        nextFrame();
        chk("respawn_132", SlotActvt, 2'b00);
        nextFrame();
        chk("respawn_133", SlotActvt, 2'b00);
        FireBtn = 1'b0;

        // Reset in the middle of a pulse clears immediately
        gotoFrame(140);
        FireBtn = 1'b1;
        nextFrame();
        chk("pre_rst_actvt", SlotActvt, 2'b01);
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_actvt", SlotActvt, 2'b00);
        chk("mid_rst_count", ShotCount, 8'd0);
        nextFrame();
        Reset_n = 1'b1;
        nextFrame();
        chk("post_rst_143", SlotActvt, 2'b00);
        nextFrame();
        chk("post_rst_144", SlotActvt, 2'b00);
        nextFrame();
        chk("post_rst_count", ShotCount, 8'd0);
        chk("post_rst_cool",  CoolBusy,  1'b0);
        FireBtn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
